sram_like_test_ram: RTL and testbench

//  Behavioural data-memory model for CPU simulation, behind the CPU's SRAM-like data port.

---
 rtl/sram_like_test_ram.sv | 76 +++++++
 tb/tb_sram_like_test_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_test_ram.sv
// Behavioural data memory behind a CPU's SRAM-like data port.
// Word-organised RAM with byte-lane stores, one request per cycle,
// and responses returned in order exactly LATENCY cycles after acceptance.
module sram_like_test_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Left unreset on purpose so benches can preload and inspect it hierarchically.
  logic [31:0] ram [0:DEPTH_WORDS-1];

  logic               accept;
  logic [AW-1:0]      word_idx;
  logic [3:0]         byte_mask;
  logic [LATENCY-1:0] pipe_valid;
  logic [31:0]        pipe_data [0:LATENCY-1];
  logic               unused_addr_hi;

  assign accept         = data_req & rst;
  assign data_addr_ok   = accept;
  assign word_idx       = data_addr[AW+1:2];
  // Address bits above the array wrap (alias) and are intentionally ignored.
  assign unused_addr_hi = ^data_addr[31:AW+2];

  // Lane mask from access size, shifted by the byte offset; lanes past 3 fall off.
  always_comb begin
    byte_mask = '0;
    case (data_size)
      2'd0:    byte_mask = 4'b0001 << data_addr[1:0];
      2'd1:    byte_mask = 4'b0011 << data_addr[1:0];
      default: byte_mask = 4'b1111 << data_addr[1:0];
    endcase
  end

  // Commit the masked lanes of an accepted store; reset never touches the array.
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_mask[b]) ram[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Response shift register: reads capture the pre-write word, writes return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= (accept && !data_wr) ? ram[word_idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign data_data_ok = pipe_valid[LATENCY-1];
  assign data_rdata   = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_sram_like_test_ram.sv
// Self-checking bench for sram_like_test_ram: directed vector table,
// reset corner sequence, and randomized traffic against a reference model.
module tb_sram_like_test_ram;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  always #5 clk = ~clk;

  sram_like_test_ram #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_req(data_req),
    .data_wr(data_wr),
    .data_size(data_size),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  resp_t       exp_q[$];
  vec_t        vecs[$];
  logic [31:0] model [0:DEPTH-1];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic vec_t mk(input logic req, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    return v;
  endfunction

  function automatic int unsigned widx(input logic [31:0] addr);
    return (addr / 4) % DEPTH;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // Store model: write `nbytes` consecutive bytes from the addressed byte, dropping any past the word end.
  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int unsigned nbytes;
    int unsigned lane;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int unsigned b = 0; b < nbytes; b++) begin
      lane = addr % 4 + b;
      if (lane < 4) model[widx(addr)][8*lane +: 8] = wdata[8*lane +: 8];
    end
  endtask

  task automatic check_resp();
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      check("data_ok", {31'b0, data_data_ok}, 32'd1);
      check("rdata", data_rdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("data_ok_idle", {31'b0, data_data_ok}, 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_resp();
  endtask

  // Starts and ends at 1ns after a rising edge.
  task automatic do_cycle(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic use_exp, input logic [31:0] exp_v);
    resp_t r;
    data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    @(negedge clk);
    check("addr_ok", {31'b0, data_addr_ok}, {31'b0, req & rst});
    if (req && rst) begin
      r.due  = cyc + LAT;
      r.data = wr ? 32'd0 : (use_exp ? exp_v : model[widx(addr)]);
      exp_q.push_back(r);
      if (wr) model_write(addr, size, wdata);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dut.ram[i] = '0;
      model[i]   = '0;
    end

    // Reset state
    tick();
    tick();
    check("rst_rdata", data_rdata, 32'd0);
    check("rst_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed vector table
    vecs.push_back(mk(1, 1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 2'd2, 32'h10,   32'h11223344, 32'h0));
    vecs.push_back(mk(1, 1, 2'd0, 32'h13,   32'hAB000000, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h10,   32'h0,        32'hAB223344));
    vecs.push_back(mk(1, 1, 2'd1, 32'h22,   32'h55660000, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h20,   32'h0,        32'h55660000));
    vecs.push_back(mk(0, 0, 2'd0, 32'h0,    32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 2'd1, 32'h31,   32'h00CCDD00, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h30,   32'h0,        32'h00CCDD00));
    vecs.push_back(mk(1, 1, 2'd2, 32'h1000, 32'h1,        32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h0,    32'h0,        32'h1));
    vecs.push_back(mk(1, 1, 2'd2, 32'h43,   32'h77FFFFFF, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h40,   32'h0,        32'h77000000));
    vecs.push_back(mk(1, 1, 2'd3, 32'h50,   32'h12345678, 32'h0));
    vecs.push_back(mk(1, 1, 2'd0, 32'h51,   32'h0000EE00, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h50,   32'h0,        32'h1234EE78));
    // Back-to-back: rd A, rd B, wr A, rd A
    vecs.push_back(mk(1, 0, 2'd2, 32'h10,   32'h0,        32'hAB223344));
    vecs.push_back(mk(1, 0, 2'd2, 32'h20,   32'h0,        32'h55660000));
    vecs.push_back(mk(1, 1, 2'd2, 32'h10,   32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h10,   32'h0,        32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 2'd0, 32'h0,    32'h0,        32'h0));

    foreach (vecs[k])
      do_cycle(vecs[k].req, vecs[k].wr, vecs[k].size, vecs[k].addr, vecs[k].wdata, 1'b1, vecs[k].rdata);

    // Randomized traffic over a small aliased word set
    for (int n = 0; n < 400; n++) begin
      logic        r_req, r_wr;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;
      r_req   = ($urandom_range(0, 3) != 0);
      r_wr    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_addr  = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) * 4) | $urandom_range(0, 3);
      r_wdata = $urandom;
      do_cycle(r_req, r_wr, r_size, r_addr, r_wdata, 1'b0, 32'h0);
    end

    // Reset while a read is in flight
    do_cycle(1, 1, 2'd2, 32'h60, 32'h5A5AA5A5, 1'b0, 32'h0);
    do_cycle(1, 0, 2'd2, 32'h60, 32'h0,        1'b0, 32'h0);
    data_req = 1'b1;
    data_wr  = 1'b0;
    rst      = 1'b0;
    #1;
    check("midrst_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    check("midrst_data_ok", {31'b0, data_data_ok}, 32'd0);
    check("midrst_rdata", data_rdata, 32'd0);
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    data_req = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    do_cycle(1, 0, 2'd2, 32'h60, 32'h0, 1'b1, 32'h5A5AA5A5);
    do_cycle(1, 0, 2'd2, 32'h50, 32'h0, 1'b0, 32'h0);
    for (int d = 0; d < int'(LAT) + 1; d++)
      do_cycle(0, 0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("pending_responses", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
